// File: rtl/reorder_buffer_ng_pkg.sv
// rob_pkg: shared definitions for the reorder buffer.
//   - default geometry (ROB_DEPTH, XLEN)
//   - 6-bit op encodings seen on alloc_op
//   - store size codes driven on mem_wr_size
//   - commit FSM state type
//   - small op-classification helpers used by the commit logic
package rob_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int XLEN      = 32;

    // Op encodings. Branches occupy a contiguous block, stores another.
    localparam logic [5:0] OP_ALU  = 6'd0;
    localparam logic [5:0] OP_LUI  = 6'd1;
    localparam logic [5:0] OP_LOAD = 6'd2;
    localparam logic [5:0] OP_JAL  = 6'd3;
    localparam logic [5:0] OP_JALR = 6'd4;
    localparam logic [5:0] OP_BEQ  = 6'd8;
    localparam logic [5:0] OP_BNE  = 6'd9;
    localparam logic [5:0] OP_BLT  = 6'd10;
    localparam logic [5:0] OP_BGE  = 6'd11;
    localparam logic [5:0] OP_BLTU = 6'd12;
    localparam logic [5:0] OP_BGEU = 6'd13;
    localparam logic [5:0] OP_SB   = 6'd16;
    localparam logic [5:0] OP_SH   = 6'd17;
    localparam logic [5:0] OP_SW   = 6'd18;

    // Store sizes as presented on mem_wr_size.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_IDLE,
        ST_STORE_WAIT
    } commit_state_e;

    function automatic logic is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic is_branch(input logic [5:0] op);
        return (op >= OP_BEQ) && (op <= OP_BGEU);
    endfunction

    function automatic logic [1:0] store_size(input logic [5:0] op);
        logic [1:0] sz;
        sz = SZ_WORD;
        if (op == OP_SB) sz = SZ_BYTE;
        if (op == OP_SH) sz = SZ_HALF;
        return sz;
    endfunction

endpackage

// File: rtl/reorder_buffer_ng_ptr.sv
// rob_ptr: wrap-bit queue pointer for the reorder buffer.
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset, forces pointer to 0
//   i_clr  synchronous clear (flush), forces pointer to 0
//   i_inc  advance by one; the MSB acts as the wrap bit
//   o_ptr  current pointer value, W bits (index + wrap bit)
module rob_ptr #(
    parameter int W = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_ptr
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) r_ptr <= '0;
        else if (i_inc)     r_ptr <= r_ptr + ONE;
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_buffer_ng.sv
// reorder_buffer_ng: in-order retirement queue for an out-of-order core.
//   i_clk/i_rst/i_rdy      clock, sync active-high reset, global enable
//   i_alloc_*              decoder allocation at tail; o_alloc_tag / o_full
//   i_cdb_*                NUM_CDB result broadcasts (ready/value/aux by tag)
//   i_rs1_tag/i_rs2_tag    operand lookup -> o_rs*_ready / o_rs*_value (comb)
//   o_commit_*             register retirement pulse
//   o_mem_wr_* / i_mem_wr_done   store handshake, request held until done
//   o_pred_*               branch outcome pulse to the predictor
//   o_flush/o_flush_pc     redirect pulse; empties the queue
module reorder_buffer_ng
    import rob_pkg::*;
#(
    parameter int DEPTH   = ROB_DEPTH,
    parameter int NUM_CDB = 2,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_rdy,
    input  logic                             i_alloc_valid,
    input  logic [5:0]                       i_alloc_op,
    input  logic [XLEN-1:0]                  i_alloc_pc,
    input  logic [4:0]                       i_alloc_rd,
    input  logic                             i_alloc_pred_jump,
    output logic [TAG_W-1:0]                 o_alloc_tag,
    output logic                             o_full,
    input  logic [NUM_CDB-1:0]               i_cdb_valid,
    input  logic [NUM_CDB-1:0][TAG_W-1:0]    i_cdb_tag,
    input  logic [NUM_CDB-1:0][XLEN-1:0]     i_cdb_value,
    input  logic [NUM_CDB-1:0][XLEN-1:0]     i_cdb_aux,
    input  logic [TAG_W-1:0]                 i_rs1_tag,
    input  logic [TAG_W-1:0]                 i_rs2_tag,
    output logic                             o_rs1_ready,
    output logic                             o_rs2_ready,
    output logic [XLEN-1:0]                  o_rs1_value,
    output logic [XLEN-1:0]                  o_rs2_value,
    output logic                             o_commit_valid,
    output logic [4:0]                       o_commit_rd,
    output logic [XLEN-1:0]                  o_commit_value,
    output logic [TAG_W-1:0]                 o_commit_tag,
    output logic                             o_mem_wr_valid,
    output logic [1:0]                       o_mem_wr_size,
    output logic [XLEN-1:0]                  o_mem_wr_addr,
    output logic [XLEN-1:0]                  o_mem_wr_data,
    input  logic                             i_mem_wr_done,
    output logic                             o_pred_valid,
    output logic [XLEN-1:0]                  o_pred_pc,
    output logic                             o_pred_taken,
    output logic                             o_flush,
    output logic [XLEN-1:0]                  o_flush_pc
);

    // Entry storage. Only the ready bits need a reset; payload is
    // qualified by ready everywhere it is consumed.
    logic [DEPTH-1:0] r_ready;
    logic [DEPTH-1:0] r_pred;
    logic [5:0]       r_op    [DEPTH];
    logic [XLEN-1:0]  r_pc    [DEPTH];
    logic [4:0]       r_rd    [DEPTH];
    logic [XLEN-1:0]  r_value [DEPTH];
    logic [XLEN-1:0]  r_aux   [DEPTH];

    commit_state_e r_state, w_state_nxt;

    logic [TAG_W:0]   w_head, w_tail;
    logic [TAG_W-1:0] w_head_idx, w_tail_idx;
    logic             w_empty, w_head_rdy, w_retire, w_alloc;

    assign w_head_idx = w_head[TAG_W-1:0];
    assign w_tail_idx = w_tail[TAG_W-1:0];

    // Same index with opposite wrap bits means every entry is occupied.
    assign w_empty     = (w_head == w_tail);
    assign o_full      = (w_head_idx == w_tail_idx) && (w_head[TAG_W] != w_tail[TAG_W]);
    assign o_alloc_tag = w_tail_idx;

    // A flush wins over a same-cycle allocation; full is judged before
    // any retirement this cycle.
    assign w_alloc = i_rdy && i_alloc_valid && !o_full && !o_flush;

    rob_ptr #(.W(TAG_W + 1)) u_head (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (o_flush),
        .i_inc (w_retire),
        .o_ptr (w_head)
    );

    rob_ptr #(.W(TAG_W + 1)) u_tail (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (o_flush),
        .i_inc (w_alloc),
        .o_ptr (w_tail)
    );

    // Operand lookup with same-cycle CDB bypass; higher channel wins.
    always_comb begin
        o_rs1_ready = r_ready[i_rs1_tag];
        o_rs1_value = r_value[i_rs1_tag];
        o_rs2_ready = r_ready[i_rs2_tag];
        o_rs2_value = r_value[i_rs2_tag];
        for (int i = 0; i < NUM_CDB; i++) begin
            if (i_cdb_valid[i] && (i_cdb_tag[i] == i_rs1_tag)) begin
                o_rs1_ready = 1'b1;
                o_rs1_value = i_cdb_value[i];
            end
            if (i_cdb_valid[i] && (i_cdb_tag[i] == i_rs2_tag)) begin
                o_rs2_ready = 1'b1;
                o_rs2_value = i_cdb_value[i];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ready <= '0;
        end else if (i_rdy) begin
            if (o_flush) begin
                r_ready <= '0;
            end else begin
                if (w_alloc) begin
                    r_ready[w_tail_idx] <= 1'b0;
                    r_pred[w_tail_idx]  <= i_alloc_pred_jump;
                    r_op[w_tail_idx]    <= i_alloc_op;
                    r_pc[w_tail_idx]    <= i_alloc_pc;
                    r_rd[w_tail_idx]    <= i_alloc_rd;
                end
                // Later iterations override earlier ones on a tag collision.
                for (int i = 0; i < NUM_CDB; i++) begin
                    if (i_cdb_valid[i]) begin
                        r_ready[i_cdb_tag[i]] <= 1'b1;
                        r_value[i_cdb_tag[i]] <= i_cdb_value[i];
                        r_aux[i_cdb_tag[i]]   <= i_cdb_aux[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)      r_state <= ST_IDLE;
        else if (i_rdy) r_state <= w_state_nxt;
    end

    // Commit decision for the head entry. Pulses are only raised while
    // i_rdy is high; the store request is state and stays visible.
    always_comb begin
        w_state_nxt    = r_state;
        w_retire       = 1'b0;
        o_commit_valid = 1'b0;
        o_commit_rd    = '0;
        o_commit_value = '0;
        o_commit_tag   = '0;
        o_mem_wr_valid = 1'b0;
        o_mem_wr_size  = '0;
        o_mem_wr_addr  = '0;
        o_mem_wr_data  = '0;
        o_pred_valid   = 1'b0;
        o_pred_pc      = '0;
        o_pred_taken   = 1'b0;
        o_flush        = 1'b0;
        o_flush_pc     = '0;
        w_head_rdy     = !w_empty && r_ready[w_head_idx];

        case (r_state)
            ST_STORE_WAIT: begin
                o_mem_wr_valid = 1'b1;
                o_mem_wr_size  = store_size(r_op[w_head_idx]);
                o_mem_wr_addr  = r_aux[w_head_idx];
                o_mem_wr_data  = r_value[w_head_idx];
                if (i_rdy && i_mem_wr_done) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                if (i_rdy && w_head_rdy) begin
                    if (is_store(r_op[w_head_idx])) begin
                        w_state_nxt = ST_STORE_WAIT;
                    end else if (is_branch(r_op[w_head_idx])) begin
                        w_retire     = 1'b1;
                        o_pred_valid = 1'b1;
                        o_pred_pc    = r_pc[w_head_idx];
                        o_pred_taken = r_value[w_head_idx][0];
                        if (r_value[w_head_idx][0] != r_pred[w_head_idx]) begin
                            o_flush    = 1'b1;
                            o_flush_pc = r_value[w_head_idx][0] ? r_aux[w_head_idx]
                                                                : r_pc[w_head_idx] + XLEN'(4);
                        end
                    end else begin
                        w_retire       = 1'b1;
                        o_commit_valid = 1'b1;
                        o_commit_rd    = r_rd[w_head_idx];
                        o_commit_value = r_value[w_head_idx];
                        o_commit_tag   = w_head_idx;
                        if (r_op[w_head_idx] == OP_JALR) begin
                            o_flush    = 1'b1;
                            o_flush_pc = r_aux[w_head_idx];
                        end
                    end
                end
            end
        endcase
    end

endmodule

// File: tb/tb_reorder_buffer_ng.sv
// Directed and randomized bench for reorder_buffer_ng, checked against a
// queue-based model of the buffer's contents.
module tb_reorder_buffer_ng;
    import rob_pkg::*;

    localparam int D  = 16;
    localparam int NC = 2;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                    rst, rdy, a_v, a_pj, done;
    logic [5:0]              a_op;
    logic [31:0]             a_pc;
    logic [4:0]              a_rd;
    logic [NC-1:0]           cv;
    logic [NC-1:0][TW-1:0]   ct;
    logic [NC-1:0][31:0]     cval, caux;
    logic [TW-1:0]           rs1t, rs2t;

    logic [TW-1:0] alloc_tag, commit_tag;
    logic          full, rs1_ready, rs2_ready, commit_valid, mem_wr_valid;
    logic          pred_valid, pred_taken, flush;
    logic [31:0]   rs1_value, rs2_value, commit_value, mem_wr_addr, mem_wr_data;
    logic [31:0]   pred_pc, flush_pc;
    logic [4:0]    commit_rd;
    logic [1:0]    mem_wr_size;

    reorder_buffer_ng #(.DEPTH(D), .NUM_CDB(NC), .TAG_W(TW)) dut (
        .i_clk(clk), .i_rst(rst), .i_rdy(rdy),
        .i_alloc_valid(a_v), .i_alloc_op(a_op), .i_alloc_pc(a_pc),
        .i_alloc_rd(a_rd), .i_alloc_pred_jump(a_pj),
        .o_alloc_tag(alloc_tag), .o_full(full),
        .i_cdb_valid(cv), .i_cdb_tag(ct), .i_cdb_value(cval), .i_cdb_aux(caux),
        .i_rs1_tag(rs1t), .i_rs2_tag(rs2t),
        .o_rs1_ready(rs1_ready), .o_rs2_ready(rs2_ready),
        .o_rs1_value(rs1_value), .o_rs2_value(rs2_value),
        .o_commit_valid(commit_valid), .o_commit_rd(commit_rd),
        .o_commit_value(commit_value), .o_commit_tag(commit_tag),
        .o_mem_wr_valid(mem_wr_valid), .o_mem_wr_size(mem_wr_size),
        .o_mem_wr_addr(mem_wr_addr), .o_mem_wr_data(mem_wr_data),
        .i_mem_wr_done(done),
        .o_pred_valid(pred_valid), .o_pred_pc(pred_pc), .o_pred_taken(pred_taken),
        .o_flush(flush), .o_flush_pc(flush_pc)
    );

    int checks = 0;
    int errors = 0;

    // Model: live entries oldest-first, next tag to hand out, store in flight.
    typedef struct {
        logic [5:0]  op;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        pj;
        bit          rd_y;
        logic [31:0] val;
        logic [31:0] aux;
        int          tag;
    } ent_t;

    ent_t q[$];
    int   tail_tag = 0;
    bit   swait    = 1'b0;

    function automatic bit m_store(input logic [5:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic bit m_branch(input logic [5:0] op);
        return op == OP_BEQ || op == OP_BNE || op == OP_BLT ||
               op == OP_BGE || op == OP_BLTU || op == OP_BGEU;
    endfunction

    function automatic logic [1:0] m_size(input logic [5:0] op);
        if (op == OP_SB) return 2'd0;
        if (op == OP_SH) return 2'd1;
        return 2'd2;
    endfunction

    function automatic int find(input int t);
        foreach (q[i]) if (q[i].tag == t) return i;
        return -1;
    endfunction

    function automatic logic [5:0] rand_op();
        case ($urandom_range(0, 15))
            0, 1, 2, 3, 4, 5, 6: return OP_ALU;
            7:  return OP_LOAD;
            8:  return OP_LUI;
            9:  return OP_SB;
            10: return OP_SH;
            11: return OP_SW;
            12: return OP_BEQ;
            13: return OP_BNE;
            14: return OP_BLTU;
            default: return OP_JALR;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
        end
    endtask

    task automatic chk_rs(input string nm, input logic [TW-1:0] t,
                          input logic ordy, input logic [31:0] oval);
        int k;
        bit known, er;
        logic [31:0] ev;
        k = find(int'(t));
        known = (k >= 0);
        er = 1'b0;
        ev = '0;
        if (known) begin er = q[k].rd_y; ev = q[k].val; end
        for (int c = 0; c < NC; c++)
            if (cv[c] && ct[c] == t) begin er = 1'b1; ev = cval[c]; known = 1'b1; end
        if (known) begin
            chk({nm, "_ready"}, ordy, er);
            if (er) chk({nm, "_value"}, oval, ev);
        end
    endtask

    task automatic idle();
        rst = 0; rdy = 1; a_v = 0; a_op = '0; a_pc = '0; a_rd = '0; a_pj = 0;
        cv = '0; ct = '0; cval = '0; caux = '0; rs1t = '0; rs2t = '0; done = 0;
    endtask

    // Inputs are driven before the call (after a falling edge). Checks the
    // combinational outputs, then advances model and clock by one cycle.
    task automatic step();
        bit e_cv, e_pv, e_fl, e_mv, e_tk, ret, gow;
        logic [31:0] e_cval, e_ppc, e_fpc, e_ma, e_md;
        logic [4:0]  e_crd;
        logic [1:0]  e_ms;
        int e_ctag, pre, k;
        e_cv = 0; e_pv = 0; e_fl = 0; e_mv = 0; e_tk = 0; ret = 0; gow = 0;
        e_cval = '0; e_ppc = '0; e_fpc = '0; e_ma = '0; e_md = '0;
        e_crd = '0; e_ms = '0; e_ctag = 0;
        #1;
        if (swait) begin
            e_mv = 1; e_ms = m_size(q[0].op); e_ma = q[0].aux; e_md = q[0].val;
            ret = rdy && done;
        end else if (rdy && q.size() > 0 && q[0].rd_y) begin
            if (m_store(q[0].op)) begin
                gow = 1;
            end else if (m_branch(q[0].op)) begin
                ret = 1; e_pv = 1; e_ppc = q[0].pc; e_tk = q[0].val[0];
                if (e_tk != q[0].pj) begin
                    e_fl = 1;
                    e_fpc = e_tk ? q[0].aux : q[0].pc + 32'd4;
                end
            end else begin
                ret = 1; e_cv = 1; e_crd = q[0].rd; e_cval = q[0].val; e_ctag = q[0].tag;
                if (q[0].op == OP_JALR) begin e_fl = 1; e_fpc = q[0].aux; end
            end
        end
        chk("full", full, q.size() == D);
        chk("alloc_tag", alloc_tag, tail_tag);
        chk("commit_valid", commit_valid, e_cv);
        chk("commit_rd", commit_rd, e_crd);
        chk("commit_value", commit_value, e_cval);
        chk("commit_tag", commit_tag, e_ctag);
        chk("mem_wr_valid", mem_wr_valid, e_mv);
        chk("mem_wr_size", mem_wr_size, e_ms);
        chk("mem_wr_addr", mem_wr_addr, e_ma);
        chk("mem_wr_data", mem_wr_data, e_md);
        chk("pred_valid", pred_valid, e_pv);
        chk("pred_pc", pred_pc, e_ppc);
        chk("pred_taken", pred_taken, e_tk);
        chk("flush", flush, e_fl);
        chk("flush_pc", flush_pc, e_fpc);
        chk_rs("rs1", rs1t, rs1_ready, rs1_value);
        chk_rs("rs2", rs2t, rs2_ready, rs2_value);
        @(posedge clk);
        if (rst || (rdy && e_fl)) begin
            q.delete(); tail_tag = 0; swait = 0;
        end else if (rdy) begin
            pre = q.size();
            if (gow) swait = 1;
            if (ret) begin void'(q.pop_front()); swait = 0; end
            if (a_v && pre < D) begin
                q.push_back('{op: a_op, pc: a_pc, rd: a_rd, pj: a_pj, rd_y: 1'b0,
                              val: 32'd0, aux: 32'd0, tag: tail_tag});
                tail_tag = (tail_tag + 1) % D;
            end
            for (int c = 0; c < NC; c++) begin
                if (cv[c]) begin
                    k = find(int'(ct[c]));
                    if (k >= 0) begin q[k].rd_y = 1; q[k].val = cval[c]; q[k].aux = caux[c]; end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic alloc(input logic [5:0] op, input logic [31:0] pc,
                         input logic [4:0] rd, input logic pj);
        idle(); a_v = 1; a_op = op; a_pc = pc; a_rd = rd; a_pj = pj;
        step();
    endtask

    task automatic res(input int ch, input int tag, input logic [31:0] v, input logic [31:0] ax);
        cv[ch] = 1'b1; ct[ch] = TW'(tag); cval[ch] = v; caux[ch] = ax;
    endtask

    task automatic do_reset();
        idle(); rst = 1; step(); idle();
    endtask

    initial begin
        int cand[$];
        int j;

        // Reset state
        idle(); rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_full", full, 0);
        chk("rst_alloc_tag", alloc_tag, 0);
        chk("rst_commit", commit_valid, 0);
        chk("rst_mem_wr", mem_wr_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_pred", pred_valid, 0);
        step();

        // Fill to full, 17th ignored, tag wraps, retire while full drops alloc
        for (int i = 0; i < 16; i++) alloc(OP_ALU, 32'h1000 + 32'(4 * i), 5'(i + 1), 1'b0);
        idle(); #1;
        chk("full_after_16", full, 1);
        chk("tag_wrap", alloc_tag, 0);
        alloc(OP_ALU, 32'h2000, 5'd9, 1'b0);
        idle(); #1;
        chk("alloc17_ignored", alloc_tag, 0);
        res(0, 0, 32'h11, 32'h0); step();
        idle(); a_v = 1; a_op = OP_ALU; #1;
        chk("retire_full_commit", commit_valid, 1);
        step();
        idle(); #1;
        chk("retire_full_drop", alloc_tag, 0);
        chk("retire_full_cnt", full, 0);
        alloc(OP_ALU, 32'h3000, 5'd4, 1'b0);
        idle(); #1;
        chk("refill_full", full, 1);
        chk("refill_tag", alloc_tag, 1);
        do_reset();

        // Same-cycle CDB bypass on operand lookup
        for (int i = 0; i < 4; i++) alloc(OP_ALU, 32'h100 + 32'(4 * i), 5'(i + 1), 1'b0);
        idle(); res(0, 3, 32'h55, 32'h0); rs1t = 4'd3; #1;
        chk("bypass_ready", rs1_ready, 1);
        chk("bypass_value", rs1_value, 32'h55);
        step();
        idle(); rs1t = 4'd3; rs2t = 4'd2; #1;
        chk("stored_ready", rs1_ready, 1);
        chk("stored_value", rs1_value, 32'h55);
        chk("unready_rs2", rs2_ready, 0);
        step();
        do_reset();

        // Store handshake
        alloc(OP_SW, 32'h200, 5'd0, 1'b0);
        idle(); res(0, 0, 32'hAB, 32'h100); step();
        idle(); #1; chk("st_first_cycle", mem_wr_valid, 0); step();
        for (int i = 0; i < 4; i++) begin
            idle(); done = (i == 3); #1;
            chk("st_valid_held", mem_wr_valid, 1);
            chk("st_addr", mem_wr_addr, 32'h100);
            chk("st_data", mem_wr_data, 32'hAB);
            chk("st_size", mem_wr_size, 2);
            step();
        end
        idle(); #1; chk("st_released", mem_wr_valid, 0); step();
        alloc(OP_ALU, 32'h204, 5'd7, 1'b0);
        idle(); res(0, 1, 32'h77, 32'h0); step();
        idle(); #1;
        chk("st_head_advanced", commit_tag, 1);
        chk("st_next_commit", commit_valid, 1);
        step();

        // Taken mispredict: flush to aux, same-cycle alloc/CDB discarded
        do_reset();
        alloc(OP_BEQ, 32'h40, 5'd0, 1'b0);
        alloc(OP_ALU, 32'h44, 5'd3, 1'b0);
        idle(); res(0, 0, 32'h1, 32'h80); step();
        idle(); a_v = 1; a_op = OP_ALU; res(1, 1, 32'h9, 32'h0); #1;
        chk("br_pred_valid", pred_valid, 1);
        chk("br_pred_pc", pred_pc, 32'h40);
        chk("br_taken", pred_taken, 1);
        chk("br_flush", flush, 1);
        chk("br_flush_pc", flush_pc, 32'h80);
        step();
        idle(); rs1t = 4'd1; #1;
        chk("br_empty_tag", alloc_tag, 0);
        chk("br_cdb_dropped", rs1_ready, 0);
        chk("br_no_commit", commit_valid, 0);
        step();

        // Correct prediction, then not-taken mispredict
        alloc(OP_BEQ, 32'h60, 5'd0, 1'b1);
        alloc(OP_BNE, 32'h70, 5'd0, 1'b1);
        idle(); res(0, 0, 32'h1, 32'h300); res(1, 1, 32'h0, 32'h99); step();
        idle(); #1;
        chk("ok_pred_valid", pred_valid, 1);
        chk("ok_no_flush", flush, 0);
        step();
        idle(); #1;
        chk("nt_flush", flush, 1);
        chk("nt_flush_pc", flush_pc, 32'h74);
        step();

        // JALR with a stall cycle
        alloc(OP_JALR, 32'h80, 5'd1, 1'b0);
        idle(); res(0, 0, 32'h84, 32'h500); step();
        idle(); rdy = 0; a_v = 1; #1;
        chk("stall_no_commit", commit_valid, 0);
        chk("stall_no_flush", flush, 0);
        step();
        idle(); #1;
        chk("jalr_commit", commit_valid, 1);
        chk("jalr_rd", commit_rd, 1);
        chk("jalr_flush_pc", flush_pc, 32'h500);
        step();

        // Reset during a pending store
        alloc(OP_SH, 32'h90, 5'd0, 1'b0);
        idle(); res(0, 0, 32'h1234, 32'h600); step();
        step();
        idle(); #1; chk("rsw_valid", mem_wr_valid, 1);
        rst = 1; step();
        idle(); #1;
        chk("rsw_mem_wr", mem_wr_valid, 0);
        chk("rsw_commit", commit_valid, 0);
        chk("rsw_tag", alloc_tag, 0);
        step(); step();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst  = ($urandom_range(0, 299) == 0);
            rdy  = ($urandom_range(0, 7) != 0);
            a_v  = ($urandom_range(0, 2) != 0);
            a_op = rand_op();
            a_pc = $urandom & 32'hFFFF_FFFC;
            a_rd = 5'($urandom);
            a_pj = 1'($urandom);
            cand.delete();
            foreach (q[i]) if (!q[i].rd_y) cand.push_back(q[i].tag);
            for (int c = 0; c < NC; c++) begin
                if (cand.size() > 0 && $urandom_range(0, 1) == 1) begin
                    j = $urandom_range(0, cand.size() - 1);
                    res(c, cand[j], $urandom, $urandom);
                    cand.delete(j);
                end
            end
            done = ($urandom_range(0, 2) == 0);
            rs1t = TW'($urandom);
            rs2t = (q.size() > 0) ? TW'(q[$urandom_range(0, q.size() - 1)].tag) : '0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
